// File: rtl/ws2812_frame_sequencer_if.sv
// Buffer write port and serializer byte stream of the WS2812 frame sequencer.
// The sequencer takes the slave side; the writer/serializer pair takes the master side.
interface ws2812_frame_sequencer_if;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       ser_valid;
    logic [7:0] ser_data;
    logic       ser_last;
    logic       ser_ready;

    modport master (
        output wr_valid, wr_addr, wr_data, ser_ready,
        input  wr_ready, ser_valid, ser_data, ser_last
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, ser_ready,
        output wr_ready, ser_valid, ser_data, ser_last
    );
endinterface

// File: rtl/ws2812_frame_sequencer.sv
// Owns the LED byte buffer, streams it to the serializer in address order on demand,
// and enforces the latch gap between frames.
module ws2812_frame_sequencer #(
    parameter int unsigned LED_CNT      = 3,
    parameter int unsigned RESET_CYCLES = 1300
) (
    input  logic                           clk,
    input  logic                           reset,
    ws2812_frame_sequencer_if.slave        bus,
    input  logic                           refresh_i,
    output logic                           frame_busy
);
    localparam int unsigned BYTES = 3 * LED_CNT;
    localparam int unsigned IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int unsigned CNT_W = $clog2(RESET_CYCLES);

    typedef enum logic [1:0] {StIdle, StLoad, StSend, StLatch} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dirty_q, dirty_d;
    logic             ser_valid_q, ser_valid_d;
    logic             ser_last_q, ser_last_d;
    logic [7:0]       ser_data_q, ser_data_d;
    logic [7:0]       mem_q [BYTES];
    logic             wr_fire;
    logic             wr_in_range;
    logic             last_byte;

    // The reader owns the buffer only during LOAD; the writer wins every other cycle.
    assign bus.wr_ready  = reset || (state_q != StLoad);
    assign frame_busy    = reset || (state_q != StIdle);
    assign bus.ser_valid = ser_valid_q;
    assign bus.ser_data  = ser_data_q;
    assign bus.ser_last  = ser_last_q;

    assign wr_fire     = bus.wr_valid && bus.wr_ready;
    assign wr_in_range = ({1'b0, bus.wr_addr} < 9'(BYTES));
    assign last_byte   = (idx_q == IDX_W'(BYTES - 1));

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        dirty_d     = dirty_q;
        ser_valid_d = ser_valid_q;
        ser_last_d  = ser_last_q;
        ser_data_d  = ser_data_q;
        unique case (state_q)
            StIdle: begin
                if (dirty_q) begin
                    state_d = StLoad;
                    dirty_d = 1'b0;
                    idx_d   = '0;
                end
            end
            StLoad: begin
                ser_data_d  = mem_q[idx_q];
                ser_last_d  = last_byte;
                ser_valid_d = 1'b1;
                state_d     = StSend;
            end
            StSend: begin
                if (ser_valid_q && bus.ser_ready) begin
                    ser_valid_d = 1'b0;
                    ser_last_d  = 1'b0;
                    if (last_byte) begin
                        state_d = StLatch;
                        cnt_d   = '0;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = StLoad;
                    end
                end
            end
            StLatch: begin
                if (cnt_q == CNT_W'(RESET_CYCLES - 1)) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StLatch;
        endcase
        // A new request overrides the clear on frame start, so it is never lost.
        if ((wr_fire && wr_in_range) || refresh_i) begin
            dirty_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StLatch;
            idx_q       <= '0;
            cnt_q       <= '0;
            dirty_q     <= 1'b0;
            ser_valid_q <= 1'b0;
            ser_last_q  <= 1'b0;
            ser_data_q  <= 8'h00;
            for (int unsigned i = 0; i < BYTES; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            dirty_q     <= dirty_d;
            ser_valid_q <= ser_valid_d;
            ser_last_q  <= ser_last_d;
            ser_data_q  <= ser_data_d;
            for (int unsigned i = 0; i < BYTES; i++) begin
                if (wr_fire && wr_in_range && (bus.wr_addr == 8'(i))) begin
                    mem_q[i] <= bus.wr_data;
                end
            end
        end
    end
endmodule

// File: doc/ws2812_frame_sequencer.md
Name: ws2812_frame_sequencer

Overview:
- Owns the LED colour byte buffer and shares it between two users: the I2C register-write path (writer) and the WS2812 bit serializer (reader).
- Decides when a frame is sent: it streams all buffered bytes to the serializer in address order, then enforces the latch/reset low gap.
- Frames are started by buffer writes or an explicit refresh request.
- Sits between the I2C slave front end and the single-wire serializer driving led_o.

Parameters:
- LED_CNT, 3, number of chained LEDs; buffer holds BYTES = 3*LED_CNT bytes (G,R,B per LED, address 0 sent first). Legal range 1..85.
- RESET_CYCLES, 1300, clk cycles of the latch gap (≥50 µs at 25 MHz). Minimum 2.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- wr_valid  input  1  write request from I2C path
- wr_ready  output  1  writer may transfer this cycle
- wr_addr  input  8  buffer byte address
- wr_data  input  8  byte to store
- refresh_i  input  1  single-cycle pulse: request a frame without data change
- ser_valid  output  1  byte offered to serializer
- ser_data  output  8  byte offered, MSB sent first by serializer
- ser_last  output  1  qualifies final byte of frame
- ser_ready  input  1  serializer accepts byte when ser_valid&&ser_ready
- frame_busy  output  1  high in LOAD, SEND, LATCH

Behaviour:
- Reset (synchronous, active-high): all buffer bytes 0x00; dirty=0; idx=0; gap counter=0; state=LATCH, so the line is guaranteed low for RESET_CYCLES after reset.
- Output values while reset is held: ser_valid=0, ser_data=0x00, ser_last=0, frame_busy=1, wr_ready=1.
- States and transitions:
  - IDLE: if dirty, go to LOAD next cycle; clear dirty; idx=0.
  - LOAD: one cycle; buffer read port owned by the reader; wr_ready=0. Register ser_data<=buf[idx], ser_last<=(idx==BYTES-1), ser_valid<=1. Go to SEND.
  - SEND: hold ser_valid/ser_data/ser_last stable until handshake.
    - On handshake: ser_valid<=0, ser_last<=0.
    - If idx==BYTES-1: go to LATCH, counter=0.
    - Else: idx<=idx+1, go to LOAD.
  - LATCH: counter increments each cycle; when counter==RESET_CYCLES-1, go to IDLE. Gap is exactly RESET_CYCLES cycles in LATCH.
- Latency: dirty observed in IDLE at cycle N → LOAD at N+1 → ser_valid=1 at N+2.
- Per-byte cost: minimum 2 cycles (LOAD + SEND with ser_ready already high).
- wr_ready = 1 in every state except LOAD (writer has priority otherwise; reader wins only in LOAD). Combinational from state.
- Write accepted when wr_valid&&wr_ready at the edge:
  - wr_addr<BYTES: byte stored, dirty<=1.
  - wr_addr≥BYTES: accepted and dropped, dirty unchanged.
- Writes during a frame are allowed and take effect immediately:
  - Byte not yet loaded: appears in the current frame.
  - Byte already loaded/sent: appears next frame.
  - Either way dirty=1, so another frame follows the latch gap.
- refresh_i=1 in any state sets dirty<=1 (pending), never aborts or restarts a frame.
- Simultaneous IDLE→LOAD dirty clear with an accepted in-range write or refresh_i: set wins, dirty stays 1.
- Back-to-back frames always separated by full LATCH; no frame starts while in LATCH.
- Reset mid-frame: next edge ser_valid=0, buffer cleared, LATCH entered; serializer must discard its partial byte.
- idx width = clog2(BYTES), minimum 1; counter width = clog2(RESET_CYCLES); no wrap beyond terminal values.

Test Plan:
Bench parameters for all scenarios: LED_CNT=3, RESET_CYCLES=16.
1. Release reset, no writes → frame_busy high exactly 16 cycles, then 0; ser_valid never asserts.
2. Write addr 0..8 = AB,36,84,D0,25,5A,11,22,33, ser_ready tied 1 → ser_valid first high 2 cycles after IDLE sees dirty; bytes appear in that order at 2-cycle spacing, ser_last only with 0x33; then 16-cycle LATCH; exactly one frame sent.
3. ser_ready held low 5 cycles on byte 0x36 → ser_data/ser_valid stable throughout; wr_ready=1 during stall; next byte 0x84 only after handshake.
4. Frame in progress, write addr 8=0x99 before its LOAD and addr 0=0x77 after byte 0 sent → current frame ends 0x99; second frame starts after 16-cycle gap with first byte 0x77.
5. Write addr 0x0C=0xFF and a wr_valid collision during LOAD → out-of-range write causes no frame; LOAD-cycle write sees wr_ready=0 and completes the following cycle.
6. refresh_i pulse in LATCH plus reset asserted mid-SEND → refresh yields one frame of current buffer after gap; reset drops ser_valid next edge, buffer reads back 0x00, 16-cycle LATCH precedes any new frame.
